bit_scan_unit: RTL



---
 rtl/bit_scan_pkg.sv | 8 +
 rtl/bit_scan_if.sv | 16 +
 rtl/bit_scan_chunk_enc.sv | 28 ++
 rtl/bit_scan_unit.sv | 107 ++++++++++
 4 files changed

// File: rtl/bit_scan_pkg.sv
// bit_scan_pkg: op encodings and FSM state type shared by the bit-scan unit
package bit_scan_pkg;
  localparam logic [1:0] OP_CTZ  = 2'b00;
  localparam logic [1:0] OP_CLZ  = 2'b01;
  localparam logic [1:0] OP_CPOP = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
endpackage

// File: rtl/bit_scan_if.sv
// bit_scan_if: request/response valid-ready bundle for the bit-scan unit
interface bit_scan_if #(parameter int WIDTH = 32);
  localparam int RW = $clog2(WIDTH) + 1;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [RW-1:0]    out_result;
  logic             out_zero;
  modport master (output in_valid, in_data, in_op, out_ready,
                  input  in_ready, out_valid, out_result, out_zero);
  modport slave  (input  in_valid, in_data, in_op, out_ready,
                  output in_ready, out_valid, out_result, out_zero);
endinterface

// File: rtl/bit_scan_chunk_enc.sv
// bit_scan_chunk_enc: per-chunk nonzero flag, trailing-zero index and (BIT_SCAN_CPOP_EN) popcount
module bit_scan_chunk_enc #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0]         chunk,
  output logic                     nz,
  output logic [$clog2(CHUNK)-1:0] tz
`ifdef BIT_SCAN_CPOP_EN
  ,
  output logic [$clog2(CHUNK):0]   cnt
`endif
);
  localparam int TW = $clog2(CHUNK);
  // lowest set bit wins: scan from the top so the last hit is the lowest index
  always_comb begin
    nz = |chunk;
    tz = '0;
    for (int i = CHUNK - 1; i >= 0; i--)
      if (chunk[i]) tz = TW'(i);
  end
`ifdef BIT_SCAN_CPOP_EN
  // population count of the chunk
  always_comb begin
    cnt = '0;
    for (int i = 0; i < CHUNK; i++) cnt = cnt + (TW+1)'(chunk[i]);
  end
`endif
endmodule

// File: rtl/bit_scan_unit.sv
// bit_scan_unit: multi-cycle CTZ/CLZ (and CPOP when BIT_SCAN_CPOP_EN is defined) with early exit
module bit_scan_unit
  import bit_scan_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic       clk,
  input logic       rst_n,
  bit_scan_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int RW     = $clog2(WIDTH) + 1;
  localparam int TW     = $clog2(CHUNK);
  localparam int IW     = NCHUNK > 1 ? $clog2(NCHUNK) : 1;

  state_t           state;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] rev;
  logic [1:0]       op;
  logic [RW-1:0]    acc;
  logic [IW-1:0]    idx;
  logic [RW-1:0]    result;
  logic             zero;
  logic             nz;
  logic [TW-1:0]    tz;
  logic             last;

  assign last           = idx == IW'(NCHUNK - 1);
  assign bus.in_ready   = state == IDLE;
  assign bus.out_valid  = state == DONE;
  assign bus.out_result = result;
  assign bus.out_zero   = zero;

`ifdef BIT_SCAN_CPOP_EN
  logic [TW:0]   cnt;
  logic [RW-1:0] pop_sum;
  assign pop_sum = acc + RW'(cnt);
  bit_scan_chunk_enc #(.CHUNK(CHUNK)) u_enc (.chunk(sh[CHUNK-1:0]), .nz(nz), .tz(tz), .cnt(cnt));
`else
  bit_scan_chunk_enc #(.CHUNK(CHUNK)) u_enc (.chunk(sh[CHUNK-1:0]), .nz(nz), .tz(tz));
`endif

  // bit-reverse the operand so CLZ becomes a CTZ scan
  always_comb begin
    rev = '0;
    for (int i = 0; i < WIDTH; i++) rev[i] = bus.in_data[WIDTH-1-i];
  end

  // FSM: accept, scan one chunk per cycle, hold result until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sh     <= '0;
      op     <= OP_CTZ;
      acc    <= '0;
      idx    <= '0;
      result <= '0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          sh    <= bus.in_op == OP_CLZ ? rev : bus.in_data;
          op    <= bus.in_op;
          acc   <= '0;
          idx   <= '0;
          state <= SCAN;
        end
        SCAN: if (op == OP_CTZ || op == OP_CLZ) begin
          if (nz) begin
            result <= acc + RW'(tz);
            zero   <= 1'b0;
            state  <= DONE;
          end else begin
            acc <= acc + RW'(CHUNK);
            sh  <= sh >> CHUNK;
            idx <= idx + IW'(1);
            if (last) begin
              result <= RW'(WIDTH);
              zero   <= 1'b1;
              state  <= DONE;
            end
          end
        end
`ifdef BIT_SCAN_CPOP_EN
        else if (op == OP_CPOP) begin
          acc <= pop_sum;
          sh  <= sh >> CHUNK;
          idx <= idx + IW'(1);
          if (last) begin
            result <= pop_sum;
            zero   <= pop_sum == '0;
            state  <= DONE;
          end
        end
`endif
        else begin
          result <= '0;
          zero   <= 1'b0;
          state  <= DONE;
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
